unpacked_rr_arbiter: RTL and testbench



---
 rtl/unpacked_rr_arbiter_pkg.sv | 25 ++
 rtl/unpacked_rr_arbiter_if.sv | 37 +++
 rtl/unpacked_rr_arbiter_rr_pick.sv | 35 +++
 rtl/unpacked_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_unpacked_rr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unpacked_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : unpacked_arb_pkg
// Brief   : Shared types and index helpers for the unpacked round-robin arbiter
// Revision: 1.0 - initial release
// ============================================================================
package unpacked_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Width of an index or counter; never returns 0 so M=1-style corners still elaborate.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Increment with an explicit wrap so non-power-of-2 M never reaches index M.
    function automatic int rr_next(input int idx, input int m);
        return (idx >= m - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unpacked_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : unpacked_rr_arbiter_if
// Brief   : Per-requester unpacked streams plus the shared output stream
// Revision: 1.0 - initial release
// ============================================================================
interface unpacked_rr_arbiter_if #(
    parameter int M = 4,
    parameter int W = 8
);
    import unpacked_arb_pkg::*;

    localparam int c_idx_w = clog2_min1(M);

    logic               req_valid [0:M-1];
    logic [W-1:0]       req_data  [0:M-1];
    logic               req_last  [0:M-1];
    logic               req_ready [0:M-1];
    logic               out_valid;
    logic [W-1:0]       out_data;
    logic               out_last;
    logic [c_idx_w-1:0] out_src;
    logic               out_ready;
    logic               timeout_err;

    modport master (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_src, timeout_err
    );

    modport slave (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_src, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/unpacked_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational rotating-priority picker starting the scan at ptr
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
    import unpacked_arb_pkg::*;
#(
    parameter int M = 4,
    localparam int c_idx_w = clog2_min1(M)
) (
    input  logic               req [0:M-1],
    input  logic [c_idx_w-1:0] ptr,
    output logic               any,
    output logic [c_idx_w-1:0] idx
);

    logic [c_idx_w-1:0] w_pos;

    always_comb begin
        any   = 1'b0;
        idx   = '0;
        w_pos = ptr;
        for (int k = 0; k < M; k++) begin
            if (!any && req[w_pos]) begin
                any = 1'b1;
                idx = w_pos;
            end
            w_pos = c_idx_w'(rr_next(int'(w_pos), M));
        end
    end

endmodule
`default_nettype wire

// File: rtl/unpacked_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : unpacked_rr_arbiter
// Brief   : Burst-locked round-robin arbiter with stall watchdog
// Revision: 1.0 - initial release
// ============================================================================
module unpacked_rr_arbiter
    import unpacked_arb_pkg::*;
#(
    parameter int M       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    unpacked_rr_arbiter_if.master bus
);

    localparam int                c_idx_w   = clog2_min1(M);
    localparam int                c_wd_w    = clog2_min1(TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

    arb_state_t          r_state, w_state_nxt;
    logic [c_idx_w-1:0]  r_ptr, w_ptr_nxt;
    logic [c_idx_w-1:0]  r_gnt, w_gnt_nxt;
    logic [c_wd_w-1:0]   r_wd_cnt, w_wd_nxt;
    logic                r_timeout_err, w_timeout_nxt;

    logic                w_req [0:M-1];
    logic                w_any;
    logic [c_idx_w-1:0]  w_pick;
    logic                w_busy;
    logic                w_valid;
    logic                w_last;
    logic                w_xfer;
    logic [c_idx_w-1:0]  w_gnt_inc;

    always_comb begin
        for (int k = 0; k < M; k++) begin
            w_req[k] = bus.req_valid[k];
        end
    end

    rr_pick #(
        .M (M)
    ) u_pick (
        .req (w_req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    // Forwarding is gated by reset so an aborted burst moves no beat in the reset cycle.
    always_comb begin
        w_busy    = (r_state == BUSY) && !reset;
        w_valid   = w_busy && bus.req_valid[r_gnt];
        w_last    = w_busy && bus.req_last[r_gnt];
        w_xfer    = w_valid && bus.out_ready;
        w_gnt_inc = c_idx_w'(rr_next(int'(r_gnt), M));
    end

    always_comb begin
        for (int k = 0; k < M; k++) begin
            bus.req_ready[k] = w_busy && bus.out_ready && (r_gnt == c_idx_w'(k));
        end
        bus.out_valid   = w_valid;
        bus.out_last    = w_last;
        bus.out_data    = w_busy ? bus.req_data[r_gnt] : '0;
        bus.out_src     = w_busy ? r_gnt : '0;
        bus.timeout_err = r_timeout_err;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_nxt     = r_gnt;
        w_wd_nxt      = r_wd_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_wd_nxt = '0;
                if (w_any) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_xfer) begin
                    w_wd_nxt = '0;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = w_gnt_inc;
                    end
                end else if (r_wd_cnt == c_wd_last) begin
                    w_state_nxt   = IDLE;
                    w_ptr_nxt     = w_gnt_inc;
                    w_wd_nxt      = '0;
                    w_timeout_nxt = 1'b1;
                end else if (r_wd_cnt != '1) begin
                    w_wd_nxt = r_wd_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_gnt         <= '0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_gnt         <= w_gnt_nxt;
            r_wd_cnt      <= w_wd_nxt;
            r_timeout_err <= w_timeout_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unpacked_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_unpacked_rr_arbiter
// Brief   : Directed scoreboard bench for M=4 and M=3 arbiter instances
// Revision: 1.0 - initial release
// ============================================================================
module tb_unpacked_rr_arbiter;

    typedef struct packed {
        logic [3:0] src;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst;
    int    checks = 0;
    int    errors = 0;
    beat_t sb_a[$];
    beat_t sb_b[$];

    always #5 clk = ~clk;

    unpacked_rr_arbiter_if #(.M(4), .W(8)) a_if ();
    unpacked_rr_arbiter_if #(.M(3), .W(8)) b_if ();

    unpacked_rr_arbiter #(.M(4), .W(8), .TIMEOUT(15)) dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (a_if.master)
    );

    unpacked_rr_arbiter #(.M(3), .W(8), .TIMEOUT(15)) dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (b_if.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic logic [3:0] rdy_a();
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = a_if.req_ready[k];
        return r;
    endfunction

    task automatic drive_a(input int idx, input logic [7:0] d, input logic l);
        a_if.req_valid[idx] = 1'b1;
        a_if.req_data[idx]  = d;
        a_if.req_last[idx]  = l;
    endtask

    task automatic drive_b(input int idx, input logic [7:0] d, input logic l);
        b_if.req_valid[idx] = 1'b1;
        b_if.req_data[idx]  = d;
        b_if.req_last[idx]  = l;
    endtask

    task automatic push_a(input int src, input logic [7:0] d, input logic l);
        sb_a.push_back('{src: 4'(src), data: d, last: l});
    endtask

    task automatic push_b(input int src, input logic [7:0] d, input logic l);
        sb_b.push_back('{src: 4'(src), data: d, last: l});
    endtask

    task automatic clear_all();
        for (int k = 0; k < 4; k++) begin
            a_if.req_valid[k] = 1'b0;
            a_if.req_data[k]  = '0;
            a_if.req_last[k]  = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            b_if.req_valid[k] = 1'b0;
            b_if.req_data[k]  = '0;
            b_if.req_last[k]  = 1'b0;
        end
    endtask

    // Scoreboard: every accepted beat must match the oldest expected beat.
    always @(negedge clk) begin
        beat_t e, o;
        if (a_if.out_valid && a_if.out_ready) begin
            check("a_sb_has_entry", 32'(sb_a.size() != 0), 32'd1);
            if (sb_a.size() != 0) begin
                e = sb_a.pop_front();
                o = '{src: 4'(a_if.out_src), data: a_if.out_data, last: a_if.out_last};
                check("a_beat", 32'(o), 32'(e));
            end
        end
        if (b_if.out_valid && b_if.out_ready) begin
            check("b_sb_has_entry", 32'(sb_b.size() != 0), 32'd1);
            if (sb_b.size() != 0) begin
                e = sb_b.pop_front();
                o = '{src: 4'(b_if.out_src), data: b_if.out_data, last: b_if.out_last};
                check("b_beat", 32'(o), 32'(e));
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear_all();
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;

        // Reset state
        tick();
        settle();
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_out_last", 32'(a_if.out_last), 32'd0);
        check("rst_out_data", 32'(a_if.out_data), 32'd0);
        check("rst_out_src", 32'(a_if.out_src), 32'd0);
        check("rst_timeout", 32'(a_if.timeout_err), 32'd0);
        check("rst_ready", 32'(rdy_a()), 32'd0);
        tick();
        rst = 1'b0;

        // Single burst from requester 1
        drive_a(1, 8'hA1, 1'b0);
        settle();
        check("t1_bubble", 32'(a_if.out_valid), 32'd0);
        tick();
        push_a(1, 8'hA1, 1'b0);
        settle();
        check("t1_src", 32'(a_if.out_src), 32'd1);
        check("t1_ready", 32'(rdy_a()), 32'b0010);
        tick();
        drive_a(1, 8'hA2, 1'b0);
        push_a(1, 8'hA2, 1'b0);
        settle();
        tick();
        drive_a(1, 8'hA3, 1'b1);
        push_a(1, 8'hA3, 1'b1);
        settle();
        tick();
        clear_all();
        settle();
        check("t1_idle_valid", 32'(a_if.out_valid), 32'd0);
        check("t1_idle_ready", 32'(rdy_a()), 32'd0);
        tick();

        // ptr=2 beats req 0; then reset aborts req 2's burst
        drive_a(0, 8'h01, 1'b0);
        drive_a(2, 8'h21, 1'b0);
        settle();
        tick();
        push_a(2, 8'h21, 1'b0);
        settle();
        check("t2_ptr_src", 32'(a_if.out_src), 32'd2);
        tick();
        drive_a(2, 8'h22, 1'b0);
        push_a(2, 8'h22, 1'b0);
        settle();
        tick();
        drive_a(2, 8'h23, 1'b0);
        rst = 1'b1;
        settle();
        check("t2_rstcyc_valid", 32'(a_if.out_valid), 32'd0);
        check("t2_rstcyc_ready", 32'(rdy_a()), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check("t2_after_valid", 32'(a_if.out_valid), 32'd0);
        check("t2_after_ready", 32'(rdy_a()), 32'd0);
        tick();
        a_if.req_last[0] = 1'b1;
        push_a(0, 8'h01, 1'b1);
        settle();
        check("t2_ptr0_src", 32'(a_if.out_src), 32'd0);
        tick();
        clear_all();
        settle();
        check("t2_idle", 32'(a_if.out_valid), 32'd0);

        // Rotation with all requesters pending, single-beat bursts
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) drive_a(k, 8'(8'h10 + k), 1'b1);
        for (int n = 0; n < 5; n++) begin
            settle();
            check("t3_bubble", 32'(a_if.out_valid), 32'd0);
            tick();
            push_a(n % 4, 8'(8'h10 + (n % 4)), 1'b1);
            settle();
            check("t3_grant", 32'(a_if.out_src), 32'(n % 4));
            tick();
        end
        clear_all();

        // Backpressure on requester 3 (ptr=1)
        drive_a(3, 8'h31, 1'b0);
        settle();
        tick();
        push_a(3, 8'h31, 1'b0);
        settle();
        check("t4_src", 32'(a_if.out_src), 32'd3);
        tick();
        drive_a(3, 8'h32, 1'b0);
        a_if.out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            settle();
            check("t4_hold_data", 32'(a_if.out_data), 32'h32);
            check("t4_hold_ready", 32'(rdy_a()), 32'd0);
            check("t4_no_timeout", 32'(a_if.timeout_err), 32'd0);
            tick();
        end
        a_if.out_ready = 1'b1;
        push_a(3, 8'h32, 1'b0);
        settle();
        tick();
        drive_a(3, 8'h33, 1'b1);
        push_a(3, 8'h33, 1'b1);
        settle();
        tick();
        clear_all();
        settle();
        check("t4_done_valid", 32'(a_if.out_valid), 32'd0);
        check("t4_done_timeout", 32'(a_if.timeout_err), 32'd0);
        tick();

        // Watchdog: requester 0 stalls mid-burst (ptr=0)
        drive_a(0, 8'h41, 1'b0);
        settle();
        tick();
        push_a(0, 8'h41, 1'b0);
        settle();
        check("t5_src", 32'(a_if.out_src), 32'd0);
        tick();
        a_if.req_valid[0] = 1'b0;
        drive_a(1, 8'h51, 1'b1);
        for (int n = 0; n < 15; n++) begin
            settle();
            check("t5_stall_timeout", 32'(a_if.timeout_err), 32'd0);
            check("t5_stall_valid", 32'(a_if.out_valid), 32'd0);
            tick();
        end
        settle();
        check("t5_timeout_pulse", 32'(a_if.timeout_err), 32'd1);
        check("t5_idle_valid", 32'(a_if.out_valid), 32'd0);
        tick();
        push_a(1, 8'h51, 1'b1);
        settle();
        check("t5_pulse_end", 32'(a_if.timeout_err), 32'd0);
        check("t5_next_src", 32'(a_if.out_src), 32'd1);
        tick();
        clear_all();

        // M=3: last beat lands exactly when wd_cnt=14, then ptr wraps 2->0
        drive_b(2, 8'h61, 1'b1);
        b_if.out_ready = 1'b0;
        settle();
        check("t6_bubble", 32'(b_if.out_valid), 32'd0);
        tick();
        for (int n = 0; n < 14; n++) begin
            settle();
            check("t6_stall_src", 32'(b_if.out_src), 32'd2);
            check("t6_stall_timeout", 32'(b_if.timeout_err), 32'd0);
            tick();
        end
        b_if.out_ready = 1'b1;
        push_b(2, 8'h61, 1'b1);
        settle();
        tick();
        clear_all();
        drive_b(0, 8'h70, 1'b1);
        drive_b(1, 8'h71, 1'b1);
        settle();
        check("t6_clean_release", 32'(b_if.timeout_err), 32'd0);
        check("t6_idle_valid", 32'(b_if.out_valid), 32'd0);
        tick();
        push_b(0, 8'h70, 1'b1);
        settle();
        check("t6_wrap_src", 32'(b_if.out_src), 32'd0);
        tick();
        clear_all();
        settle();
        tick();

        check("sb_a_drained", 32'(sb_a.size()), 32'd0);
        check("sb_b_drained", 32'(sb_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
